// File: rtl/fe_pkg.sv
// Shared types for the FE FFT input commutator: I/Q indices, phase enum and
// complex-sample typedefs for the common component widths.
package fe_pkg;

    localparam logic I = 1'd0;
    localparam logic Q = 1'd1;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } phase_e;

    // Complex sample, index [0]=I, [1]=Q; one typedef per supported width.
    typedef logic signed [1:0][7:0]  cplx8_t;
    typedef logic signed [1:0][15:0] cplx16_t;

endpackage

// File: rtl/fe_delay_buf.sv
// Half-block delay storage for the commutator: DEPTH complex samples, one
// shared address for the write and the asynchronous read port, no reset.
module fe_delay_buf #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [1:0][W-1:0]   wdata,
    output logic [1:0][W-1:0]   rdata
);

    localparam int DEPTH = 2 ** AW;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_comp
        logic [W-1:0] mem_reg [DEPTH];

        always_ff @(posedge clk) begin
            if (we) begin
                mem_reg[addr] <= wdata[gi];
            end
        end

        assign rdata[gi] = mem_reg[addr];
    end

endmodule

// File: rtl/fe_commutator_serial.sv
// Serial input commutator for the radix-2^2 FE FFT stage: pairs x[k] with x[k+DEPTH].
// Optional status outputs (o_sof_err, o_blk_cnt) are built when FE_COMM_STATUS_EN is defined.
module fe_commutator_serial
    import fe_pkg::*;
#(
    parameter int NBW_IN = 8,
    parameter int NBI_IN = 1,
    parameter int NBW_D  = 2
) (
    input  logic                               clk,
    input  logic                               rst_async,
    input  logic                               i_valid,
    input  logic                               i_sof,
    input  logic signed [1:0][NBW_IN-1:0]      i_data,
    output logic                               o_valid,
    output logic                               o_sof,
    output logic signed [1:0][1:0][NBW_IN-1:0] o_data
`ifdef FE_COMM_STATUS_EN
    ,
    output logic                               o_sof_err,
    output logic [15:0]                        o_blk_cnt
`endif
);

    localparam logic [NBW_D-1:0] IDX_LAST = {NBW_D{1'b1}};
    localparam logic [NBW_D-1:0] IDX_ONE  = NBW_D'(1);

    // NBI_IN only documents the fixed-point format; nothing is computed here.
    if (NBW_D < 1 || NBW_D > 10 || NBI_IN > NBW_IN) begin : g_param_err
        $error("fe_commutator_serial: illegal parameter set");
    end

    phase_e                          phase_reg, phase_next;
    logic [NBW_D-1:0]                idx_reg, idx_next;
    logic                            sof_pend_reg, sof_pend_next;
    logic                            o_valid_reg, o_valid_next;
    logic                            o_sof_reg, o_sof_next;
    logic [1:0][1:0][NBW_IN-1:0]     o_data_reg, o_data_next;

    logic                            buf_we;
    logic [NBW_D-1:0]                buf_addr;
    logic [1:0][NBW_IN-1:0]          buf_rdata;

    fe_delay_buf #(
        .W  (NBW_IN),
        .AW (NBW_D)
    ) u_delay_buf (
        .clk   (clk),
        .we    (buf_we),
        .addr  (buf_addr),
        .wdata (i_data),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            phase_reg    <= FILL;
            idx_reg      <= '0;
            sof_pend_reg <= 1'b0;
            o_valid_reg  <= 1'b0;
            o_sof_reg    <= 1'b0;
            o_data_reg   <= '0;
        end else begin
            phase_reg    <= phase_next;
            idx_reg      <= idx_next;
            sof_pend_reg <= sof_pend_next;
            o_valid_reg  <= o_valid_next;
            o_sof_reg    <= o_sof_next;
            o_data_reg   <= o_data_next;
        end
    end

    always_comb begin
        phase_next    = phase_reg;
        idx_next      = idx_reg;
        sof_pend_next = sof_pend_reg;
        o_valid_next  = 1'b0;
        o_sof_next    = 1'b0;
        o_data_next   = o_data_reg;
        buf_we        = 1'b0;
        buf_addr      = idx_reg;

        if (i_valid) begin
            if (i_sof) begin
                // Realign: this sample becomes x[0] of a fresh block.
                phase_next    = FILL;
                idx_next      = IDX_ONE;
                sof_pend_next = 1'b1;
                buf_we        = 1'b1;
                buf_addr      = '0;
            end else if (phase_reg == FILL) begin
                buf_we   = 1'b1;
                idx_next = idx_reg + IDX_ONE;
                if (idx_reg == IDX_LAST) begin
                    phase_next = PAIR;
                end
            end else begin
                o_valid_next      = 1'b1;
                o_data_next[0][I] = buf_rdata[I];
                o_data_next[0][Q] = buf_rdata[Q];
                o_data_next[1][I] = i_data[I];
                o_data_next[1][Q] = i_data[Q];
                if (sof_pend_reg && idx_reg == '0) begin
                    o_sof_next    = 1'b1;
                    sof_pend_next = 1'b0;
                end
                idx_next = idx_reg + IDX_ONE;
                if (idx_reg == IDX_LAST) begin
                    phase_next = FILL;
                end
            end
        end
    end

    assign o_valid = o_valid_reg;
    assign o_sof   = o_sof_reg;
    assign o_data  = o_data_reg;

`ifdef FE_COMM_STATUS_EN
    logic        sof_err_reg;
    logic [15:0] blk_cnt_reg;
    logic        blk_done;
    logic        sof_misaligned;

    assign blk_done       = i_valid && !i_sof && (phase_reg == PAIR) && (idx_reg == IDX_LAST);
    assign sof_misaligned = i_valid && i_sof && !((phase_reg == FILL) && (idx_reg == '0));

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            sof_err_reg <= 1'b0;
            blk_cnt_reg <= '0;
        end else begin
            if (sof_misaligned) begin
                sof_err_reg <= 1'b1;
            end
            if (blk_done) begin
                blk_cnt_reg <= blk_cnt_reg + 16'd1;
            end
        end
    end

    assign o_sof_err = sof_err_reg;
    assign o_blk_cnt = blk_cnt_reg;
`endif

endmodule

// File: tb/tb_fe_commutator_serial.sv
// Directed self-checking bench for fe_commutator_serial (NBW_IN=8, DEPTH=4).
module tb_fe_commutator_serial;

    logic                  clk;
    logic                  rst_async;
    logic                  i_valid;
    logic                  i_sof;
    logic signed [1:0][7:0] i_data;
    logic                  o_valid;
    logic                  o_sof;
    logic signed [1:0][1:0][7:0] o_data;
`ifdef FE_COMM_STATUS_EN
    logic                  o_sof_err;
    logic [15:0]           o_blk_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_d;
    int sval;

    fe_commutator_serial #(
        .NBW_IN (8),
        .NBI_IN (1),
        .NBW_D  (2)
    ) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .i_valid   (i_valid),
        .i_sof     (i_sof),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .o_sof     (o_sof),
        .o_data    (o_data)
`ifdef FE_COMM_STATUS_EN
        ,
        .o_sof_err (o_sof_err),
        .o_blk_cnt (o_blk_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk3(input string tag, input logic ev, input logic es, input logic [31:0] ed);
        chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, ev});
        chk({tag, "_sof"},   {31'd0, o_sof},   {31'd0, es});
        chk({tag, "_data"},  o_data,           ed);
    endtask

    // Apply one input cycle, then sample outputs 1 time unit after the edge.
    task automatic cyc(input logic v, input logic s, input logic [7:0] di, input logic [7:0] dq);
        i_valid   = v;
        i_sof     = s;
        i_data[0] = di;
        i_data[1] = dq;
        @(posedge clk);
        #1;
    endtask

    // Expected packed pair for samples with I=a, Q=-a (earlier) and I=b, Q=-b (later).
    function automatic logic [31:0] pk(input int a, input int b);
        return {8'(-b), 8'(b), 8'(-a), 8'(a)};
    endfunction

    initial begin
        rst_async = 1'b1;
        i_valid   = 1'b0;
        i_sof     = 1'b0;
        i_data    = '0;
        exp_d     = '0;

        repeat (2) @(posedge clk);
        #1;
        chk3("rst_held", 1'b0, 1'b0, 32'd0);
        rst_async = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 8'd0, 8'd0);
            chk3("rst_idle", 1'b0, 1'b0, 32'd0);
        end
`ifdef FE_COMM_STATUS_EN
        chk("rst_sof_err", {31'd0, o_sof_err}, 32'd0);
        chk("rst_blk_cnt", {16'd0, o_blk_cnt}, 32'd0);
`endif

        // Continuous stream n=0..7 with sof on the first sample.
        for (int n = 0; n < 8; n++) begin
            cyc(1'b1, n == 0, 8'(n), 8'(-n));
            if (n >= 4) exp_d = pk(n - 4, n);
            chk3("basic", n >= 4, n == 4, exp_d);
        end

        // Same stream with an idle cycle after every sample.
        for (int n = 0; n < 8; n++) begin
            cyc(1'b1, n == 0, 8'(n), 8'(-n));
            if (n >= 4) exp_d = pk(n - 4, n);
            chk3("gap_valid", n >= 4, n == 4, exp_d);
            cyc(1'b0, 1'b0, 8'hAA, 8'h55);
            chk3("gap_idle", 1'b0, 1'b0, exp_d);
        end
`ifdef FE_COMM_STATUS_EN
        chk("pre_abort_sof_err", {31'd0, o_sof_err}, 32'd0);
`endif

        // Three samples, then sof lands at idx==DEPTH-1 in FILL and restarts.
        for (int n = 0; n < 3; n++) begin
            cyc(1'b1, 1'b0, 8'(n + 100), 8'(-(n + 100)));
            chk3("abort", 1'b0, 1'b0, exp_d);
        end
        for (int m = 0; m < 8; m++) begin
            cyc(1'b1, m == 0, 8'(16 + m), 8'(-(16 + m)));
            if (m >= 4) exp_d = pk(16 + m - 4, 16 + m);
            chk3("realign", m >= 4, m == 4, exp_d);
        end
`ifdef FE_COMM_STATUS_EN
        chk("realign_sof_err", {31'd0, o_sof_err}, 32'd1);
`endif

        // Reset in the middle of a block clears outputs immediately.
        cyc(1'b1, 1'b0, 8'd50, 8'd51);
        cyc(1'b1, 1'b0, 8'd52, 8'd53);
        rst_async = 1'b1;
        i_valid   = 1'b0;
        #1;
        exp_d = '0;
        chk3("async_rst", 1'b0, 1'b0, exp_d);
        @(posedge clk);
        #1;
        rst_async = 1'b0;

        // Two full blocks without sof: no o_sof, pairs restart at idx 0.
        for (int n = 0; n < 16; n++) begin
            cyc(1'b1, 1'b0, 8'(n), 8'(-n));
            if ((n % 8) >= 4) exp_d = pk(n - 4, n);
            chk3("wrap", (n % 8) >= 4, 1'b0, exp_d);
        end
`ifdef FE_COMM_STATUS_EN
        chk("wrap_blk_cnt", {16'd0, o_blk_cnt}, 32'd2);
        chk("wrap_sof_err", {31'd0, o_sof_err}, 32'd0);
`endif

        // Full-scale components must come through bit-exact with sign intact.
        cyc(1'b1, 1'b0, 8'h80, 8'h7F);
        cyc(1'b1, 1'b0, 8'd1, 8'd2);
        cyc(1'b1, 1'b0, 8'd3, 8'd4);
        cyc(1'b1, 1'b0, 8'd5, 8'd6);
        cyc(1'b1, 1'b0, 8'h7F, 8'h80);
        chk3("fullscale", 1'b1, 1'b0, 32'h807F_7F80);
        sval = int'($signed(o_data[0][0]));
        chk("fs_early_i_signed", 32'(sval), 32'(-128));
        sval = int'($signed(o_data[1][1]));
        chk("fs_late_q_signed", 32'(sval), 32'(-128));
        sval = int'($signed(o_data[1][0]));
        chk("fs_late_i_signed", 32'(sval), 32'(127));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fe_commutator_serial.md
Name: fe_commutator_serial

Overview:
- Serial input commutator sitting directly upstream of the serial radix-2^2 butterfly stage of the frequency-domain equaliser (FE) FFT.
- Accepts one complex sample per valid cycle.
- Stores the first half-block of DEPTH samples; while the second half-block arrives, it emits pairs (x[k], x[k+DEPTH]).
- Pairs come out in the [1:0][1:0] (sample, I/Q) layout the butterfly consumes.
- Provides frame realignment via a start-of-frame strobe.

Parameters:
- NBW_IN, 'd8, word width of each I/Q component (signed, fixed point).
- NBI_IN, 'd1, integer bits of each component; carried through unchanged because no arithmetic is performed.
- NBW_D, 'd2, log2 of the half-block delay DEPTH = 2**NBW_D. Legal range is 1..10.

Ports:
- clk  in  1  clock
- rst_async  in  1  asynchronous active-high reset
- i_valid  in  1  input sample qualifier
- i_sof  in  1  start of frame; sampled only when i_valid=1
- i_data  in  signed [NBW_IN-1:0] [1:0]  complex input; [0]=I, [1]=Q
- o_valid  out  1  output pair qualifier
- o_sof  out  1  marks the first pair of a frame
- o_data  out  signed [NBW_IN-1:0] [1:0][1:0]  [0]=earlier sample x[k], [1]=later sample x[k+DEPTH]; inner index [0]=I, [1]=Q

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst_async=1:
  - o_valid=0, o_sof=0, o_data=0.
  - Write index idx=0, phase=FILL.
  - Buffer contents are don't-care; no reset is required on the storage.
- State machine (two phases, with a counter idx of NBW_D bits):
  - FILL: on i_valid, write i_data into buf[idx] and increment idx. When idx==DEPTH-1 with i_valid, go to PAIR with idx wrapping to 0. No output is produced.
  - PAIR: on i_valid, drive o_data[0]=buf[idx] and o_data[1]=i_data, set o_valid=1, increment idx. When idx==DEPTH-1, go to FILL with idx wrapping to 0.
  - Cycles without i_valid: state, idx and buf are held. o_valid=0 next cycle; o_data keeps its last value.
- Latency: the pair is registered, so o_valid appears 1 cycle after the i_valid that delivered x[k+DEPTH].
- Throughput: DEPTH pairs per 2*DEPTH input samples. Output valids occur only in PAIR.
- o_sof: set together with o_valid for the pair with idx==0 in the first PAIR phase after an i_sof. It is 0 otherwise.
- i_sof handling (i_sof=1 with i_valid=1):
  - Forces phase=FILL.
  - The current sample is written to buf[0] and idx becomes 1, whatever the previous state.
  - A partially collected block is discarded: no output pair for it, and o_valid=0 that cycle's successor.
- Simultaneous case: i_sof arriving at idx==DEPTH-1 in FILL also restarts at FILL/idx=1. i_sof has priority over the phase transition.
- i_sof with i_valid=0 is ignored.
- Reset mid-block: all progress is lost; after release the block starts in FILL at idx 0.
- No arithmetic. Bit widths pass through unchanged, so NBI_IN is informational only.

Optional Feature:
- Macro: FE_COMM_STATUS_EN.
- When defined, two extra outputs exist:
  - o_sof_err (1 bit, sticky): set when i_sof&i_valid arrives while state≠(FILL with idx==0). Cleared only by reset.
  - o_blk_cnt (16 bits, wrapping): counts completed PAIR phases. Reset value is 0.
- When not defined, neither port nor its logic exists, and the behaviour above is unchanged.

Decomposition:
- Shared package fe_pkg holds:
  - localparams I=1'd0 and Q=1'd1.
  - typedef of the complex sample (signed [NBW_IN-1:0] [1:0]), parameterised through a macro or a class-free typedef per width.
  - the phase enum {FILL, PAIR}.
- One sub-module, fe_delay_buf: DEPTH x 2*NBW_IN register array with a write port and a read port at the same address. It has no reset, and read-before-write is not required because the address is shared and the read occurs in PAIR only.

Test Plan (NBW_IN=8, NBW_D=2, DEPTH=4):
- Reset check: assert rst_async with all inputs idle -> o_valid=0, o_sof=0, o_data all zero, and they stay so for 5 cycles after release.
- Basic pairing: i_sof on the first sample, stream continuous samples with I=n, Q=-n for n=0..7 -> pairs (0,4),(1,5),(2,6),(3,7). Each pair has o_valid 1 cycle after the later sample, and o_sof=1 only on (0,4).
- Gaps in the stream: same stream with i_valid deasserted every other cycle -> identical pair sequence, with o_valid only on the cycles following valid PAIR inputs.
- Mid-block realignment: i_sof at n=2, then 8 more samples m=0..7 -> no output for the aborted block. Pairs (m0,m4)..(m3,m7) are produced with o_sof on the first. With FE_COMM_STATUS_EN, o_sof_err=1.
- Wrap and repeat: 16 continuous samples -> 8 pairs, 2 blocks. o_blk_cnt=2 when the macro is defined.
- Full-scale values: inputs of -128 and 127 -> passed bit-exact to the output, with no sign error.
